// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle datapath.
// Latency: none, declarations only.
// Backpressure: not applicable.
// Contents: sequencer states, ALU op codes, immediate formats,
// condition codes, and the immediate extension helper.
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    ALUWB,
    MEM,
    MEMWB
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_BR = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Branch offsets are word counts, hence the sign-extend and shift by 2.
  function automatic logic [31:0] extend_imm(input logic [23:0] imm, input logic [1:0] src);
    case (src)
      IMM_8:   return {24'b0, imm[7:0]};
      IMM_12:  return {20'b0, imm[11:0]};
      IMM_BR:  return {{6{imm[23]}}, imm, 2'b00};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mc_datapath_condcheck.sv
// ARM condition evaluation against the registered NZCV flags.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: cond = instruction bits [31:28], nzcv = {N,Z,C,V}, condpass = execute enable.
module condcheck
  import mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       condpass
);

  logic n, z, c, v;

  always_comb begin
    {n, z, c, v} = nzcv;
    condpass = 1'b0;
    case (cond)
      COND_EQ: condpass = z;
      COND_NE: condpass = ~z;
      COND_CS: condpass = c;
      COND_CC: condpass = ~c;
      COND_MI: condpass = n;
      COND_PL: condpass = ~n;
      COND_VS: condpass = v;
      COND_VC: condpass = ~v;
      COND_HI: condpass = c & ~z;
      COND_LS: condpass = ~c | z;
      COND_GE: condpass = (n == v);
      COND_LT: condpass = (n != v);
      COND_GT: condpass = ~z & (n == v);
      COND_LE: condpass = z | (n != v);
      COND_AL: condpass = 1'b1;
      default: condpass = 1'b0;  // 1111 never executes
    endcase
  end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle ARM-subset datapath with built-in FETCH..MEMWB sequencer.
// Latency: 3 cycles (branch/cond-fail), 4 (ALU/store), 5 (load), plus wait states.
// Backpressure: stalls in FETCH/MEM while mem_req && !mem_ready; request fields held.
// Ports: decoder controls in (sampled DECODE..MEMWB), unified memory req/ready
// port, Instr/PC/ALUFlags state out, retire pulse and busy status.
module mc_datapath
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          NREG     = 16      // 8 or 16; top index is the PC
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  RegSrc,
  input  logic [1:0]  ImmSrc,
  input  logic        ALUSrc,
  input  logic [1:0]  ALUControl,
  input  logic        FlagW,
  input  logic        OpMem,
  input  logic        MemW,
  input  logic        OpBr,
  input  logic        RegW,
  input  logic        MemtoReg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [3:0]  ALUFlags,
  output logic        retire,
  output logic        busy
);

  localparam int             AW    = (NREG == 8) ? 3 : 4;
  localparam logic [AW-1:0]  PCIDX = AW'(NREG - 1);

  state_t        state, state_n;
  logic          req_en;  // holds off the first request until a clock after reset release
  logic [31:0]   a_q, b_q, alu_q, data_q;
  logic [31:0]   rf [NREG];

  logic          ir_en, ab_en, alu_en, flag_en, br_en, data_en, wb_en;
  logic [AW-1:0] ra1, ra2, rd;
  logic [31:0]   rd1, rd2, imm, srcb, b_eff, alu_res, wb_val;
  logic [32:0]   sum;
  logic          arith, condpass;
  logic [3:0]    alu_nzcv;

  condcheck u_condcheck (
    .cond     (Instr[31:28]),
    .nzcv     (ALUFlags),
    .condpass (condpass)
  );

  // Register reads; the PC alias reads one word ahead of the already-incremented PC.
  always_comb begin
    ra1 = RegSrc[0] ? PCIDX : Instr[16 +: AW];
    ra2 = RegSrc[1] ? Instr[12 +: AW] : Instr[0 +: AW];
    rd  = Instr[12 +: AW];
    rd1 = (ra1 == PCIDX) ? PC + 32'd4 : rf[ra1];
    rd2 = (ra2 == PCIDX) ? PC + 32'd4 : rf[ra2];
    wb_val = MemtoReg ? data_q : alu_q;
  end

  // ALU: subtraction is A + ~B + 1 so carry is the no-borrow flag.
  always_comb begin
    imm   = extend_imm(Instr[23:0], ImmSrc);
    srcb  = ALUSrc ? imm : b_q;
    b_eff = (ALUControl == ALU_SUB) ? ~srcb : srcb;
    sum   = {1'b0, a_q} + {1'b0, b_eff} + {32'b0, (ALUControl == ALU_SUB)};
    case (ALUControl)
      ALU_AND: alu_res = a_q & srcb;
      ALU_ORR: alu_res = a_q | srcb;
      default: alu_res = sum[31:0];
    endcase
    arith    = ~ALUControl[1];
    alu_nzcv = {alu_res[31], (alu_res == '0), arith & sum[32],
                arith & (a_q[31] == b_eff[31]) & (sum[31] != a_q[31])};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FETCH;
      req_en <= 1'b0;
    end else begin
      state  <= state_n;
      req_en <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = PC;
    mem_wdata = b_q;
    retire    = 1'b0;
    ir_en     = 1'b0;
    ab_en     = 1'b0;
    alu_en    = 1'b0;
    flag_en   = 1'b0;
    br_en     = 1'b0;
    data_en   = 1'b0;
    wb_en     = 1'b0;
    busy      = (state != FETCH);
    case (state)
      FETCH: begin
        mem_req = req_en;
        if (req_en && mem_ready) begin
          ir_en   = 1'b1;
          state_n = DECODE;
        end
      end
      DECODE: begin
        ab_en   = 1'b1;
        state_n = EXECUTE;
      end
      EXECUTE: begin
        if (!condpass) begin
          retire  = 1'b1;
          state_n = FETCH;
        end else begin
          flag_en = FlagW;
          if (OpBr) begin
            br_en   = 1'b1;
            retire  = 1'b1;
            state_n = FETCH;
          end else begin
            alu_en  = 1'b1;
            state_n = OpMem ? MEM : ALUWB;
          end
        end
      end
      ALUWB: begin
        wb_en   = RegW;
        retire  = 1'b1;
        state_n = FETCH;
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_addr = alu_q;
        mem_we   = MemW;
        if (mem_ready) begin
          if (MemW) begin
            retire  = 1'b1;
            state_n = FETCH;
          end else begin
            data_en = 1'b1;
            state_n = MEMWB;
          end
        end
      end
      MEMWB: begin
        wb_en   = RegW;
        retire  = 1'b1;
        state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC       <= RESET_PC;
      Instr    <= '0;
      ALUFlags <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      data_q   <= '0;
    end else begin
      if (ir_en)   Instr    <= mem_rdata;
      if (ab_en)   a_q      <= rd1;
      if (ab_en)   b_q      <= rd2;
      if (alu_en)  alu_q    <= alu_res;
      if (flag_en) ALUFlags <= alu_nzcv;
      if (data_en) data_q   <= mem_rdata;
      if (ir_en)
        PC <= PC + 32'd4;
      else if (br_en)
        PC <= alu_res;
      else if (wb_en && (rd == PCIDX))
        PC <= wb_val;
    end
  end

  // Register file is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wb_en && (rd != PCIDX))
      rf[rd] <= wb_val;
  end

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multicycle successor to the single-cycle ARM datapath: one unified memory port with a req/ready handshake, a built-in five-step sequencer, registered NZCV flags with internal condition evaluation, and a parametrised register file and reset vector. It sits between the main decoder, which stays combinational on the `Instr` output, and a single instruction/data memory. It retires one instruction every 3–5 cycles plus memory wait states.

## Interface
- `RESET_PC`, 32'h0: PC value loaded on reset.
- `NREG`, 16: register count; the top index (`NREG-1`) aliases the PC. Allowed values are 8 and 16.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `RegSrc` input 2: bit0 selects `NREG-1` as the RA1 source; bit1 selects Instr[15:12] as the RA2 source.
- `ImmSrc` input 2: 00 zero-extends Instr[7:0]; 01 zero-extends Instr[11:0]; 10 sign-extends Instr[23:0] and shifts it left by 2.
- `ALUSrc` input 1: 1 selects the extended immediate as SrcB.
- `ALUControl` input 2: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- `FlagW` input 1: update NZCV in EXECUTE.
- `OpMem`, `MemW`, `OpBr`, `RegW` input 1 each: decoded class and writes.
- `MemtoReg` input 1: writeback selects the load data.
- `mem_req` output 1, `mem_we` output 1, `mem_addr` output 32, `mem_wdata` output 32.
- `mem_rdata` input 32, `mem_ready` input 1.
- `Instr` output 32: instruction register.
- `PC` output 32, `ALUFlags` output 4: registered NZCV.
- `retire` output 1: one-cycle pulse per completed instruction.
- `busy` output 1: high whenever the sequencer is outside FETCH.

## Operation
- The decoder inputs are sampled only in DECODE through MEMWB, when `Instr` is stable.
- FETCH
  - Drives `mem_req=1`, `mem_we=0`, `mem_addr=PC`.
  - Waits while `mem_ready=0`.
  - On ready, latches `mem_rdata` into `Instr`, sets `PC<=PC+4`, and moves to DECODE.
- DECODE
  - Latches register-file reads into A and B.
  - A read of index `NREG-1` returns the current PC+4, which is the fetch address + 8.
  - Moves to EXECUTE.
- EXECUTE
  - Computes ALUOut from A and SrcB.
  - CondPass is evaluated on Instr[31:28] against the current `ALUFlags`, using the ARM codes EQ..AL; 1111 is treated as never.
  - If CondPass=0: return to FETCH with `retire` pulsed and no state change.
  - If CondPass=1 and `FlagW`: update flags.
  - Next state:
    - `OpBr`: `PC<=ALU result`, pulse `retire`, go to FETCH.
    - `OpMem`: go to MEM.
    - Otherwise: go to ALUWB.
- ALUWB
  - Writes ALUOut to Rd=Instr[15:12] when `RegW`.
  - If Rd=`NREG-1`, writes PC instead of the register file.
  - Pulses `retire` and goes to FETCH.
- MEM
  - Drives `mem_req=1`, `mem_addr=ALUOut`, `mem_we=MemW`, `mem_wdata=B`.
  - Waits while `mem_ready=0`.
  - On ready: a store pulses `retire` and goes to FETCH; a load latches `mem_rdata` and goes to MEMWB.
- MEMWB: writes the load data to Rd, with the same PC rule as ALUWB, then pulses `retire` and goes to FETCH.
- Flags:
  - N = result[31].
  - Z = (result==0).
  - ADD: C = carry-out, V = signed overflow.
  - SUB: computed as A+~B+1; C = no-borrow, V = signed overflow.
  - AND/ORR: C=0, V=0.
- All arithmetic is 32-bit modulo; PC+4 wraps from 32'hFFFFFFFC to 0.

## Timing
- Reset values:
  - PC=`RESET_PC`, `Instr`=0, `ALUFlags`=0, state=FETCH.
  - A, B, ALUOut, and the data register are all 0.
  - `retire`=0, `busy`=0. `mem_req` is high one cycle after release.
- Register-file contents are not reset.
- Latency with zero wait states:
  - Taken branch or condition-failed instruction: 3 cycles.
  - Data-processing or store: 4 cycles.
  - Load: 5 cycles.
- Each cycle with `mem_req=1` and `mem_ready=0` adds one cycle.
- `mem_addr`, `mem_we`, and `mem_wdata` are held stable while `mem_req` is high.
- `mem_ready` is ignored while `mem_req=0`.
- Reset mid-transaction drops `mem_req` asynchronously. No write completes unless `mem_ready` was already sampled.
- A register-file write to Rd and a read of the same index in the next DECODE return the new value.

## Structure
- Package `mc_pkg` holds:
  - the state enum (FETCH, DECODE, EXECUTE, ALUWB, MEM, MEMWB);
  - the ALU op codes;
  - the ImmSrc codes;
  - the condition-code constants.
- Sub-module `condcheck` takes cond[3:0] and NZCV and returns CondPass; it is purely combinational.
- The existing mux, flop, adder, extend, and alu blocks are reused and widened where needed.

## Test plan
- Reset release with `RESET_PC`=32'h100 and `mem_ready` tied high: first `mem_addr`=32'h100; after a 4-cycle ADD, the next fetch is at 32'h104.
- Instruction ADD R1 = R15 + 0 at PC 32'h100: R1 = 32'h108.
- SUBS 5−5 followed by BEQ offset 2:
  - flags become Z=1, C=1;
  - the branch target is PC+8+8;
  - `retire` pulses once per instruction.
- BNE when Z=1: 3 cycles, PC=old+4, no register or flag change.
- Store to 32'h40 with `mem_ready` low for 3 cycles:
  - `mem_addr`, `mem_we`, and `mem_wdata` are held stable;
  - the instruction completes 3 cycles late.
- LDR R15: PC is loaded from memory data and the next fetch uses that address.
- `reset` asserted mid-MEM: `mem_req` drops immediately and PC returns to `RESET_PC`.
